// File: rtl/mac_sequencer.sv
// Sequencer that feeds Q9.7 operand pairs to an external Booth multiplier
// through a start/finish handshake, and accumulates the products into a
// saturating Q9.7 dot-product result.
module mac_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic [DATA_W-1:0] mul_multiplicand,
    output logic [DATA_W-1:0] mul_multiplier,
    output logic              mul_start,
    input  logic [DATA_W-1:0] mul_result,
    input  logic              mul_overflow,
    input  logic              mul_finish,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_valid,
    output logic              acc_overflow,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_HIGH,
        ACCUM,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      timeout_hit;
    logic                      last_q;
    logic [CNT_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  acc;
    logic                      acc_ovf;
    logic signed [DATA_W-1:0]  addend;
    logic signed [DATA_W:0]    sum;
    logic signed [DATA_W-1:0]  sum_sat;
    logic                      add_sat;
    logic                      ovf_nxt;

    // Clip a one-bit-wider sum back into the signed data range.
    function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? SMIN : SMAX;
        end
        return s[DATA_W-1:0];
    endfunction

    // A product the multiplier flagged as overflowed is replaced by the
    // full-scale value of its sign before it reaches the accumulator.
    always_comb begin
        addend  = mul_overflow ? (mul_result[DATA_W-1] ? SMIN : SMAX) : $signed(mul_result);
        sum     = $signed({acc[DATA_W-1], acc}) + $signed({addend[DATA_W-1], addend});
        sum_sat = sat_narrow(sum);
        add_sat = (sum[DATA_W] != sum[DATA_W-1]);
        ovf_nxt = acc_ovf | mul_overflow | add_sat;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the handshake waits expect finish to drop first so
    // a finish level left over from the previous product is never taken.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!mul_finish) begin
                    state_nxt = WAIT_HIGH;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (mul_finish) begin
                    state_nxt = ACCUM;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ACCUM: begin
                state_nxt = last_q ? DONE : IDLE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, operand latch, wait counter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready         <= 1'b1;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            last_q           <= 1'b0;
            acc_out          <= '0;
            acc_valid        <= 1'b0;
            acc_overflow     <= 1'b0;
            timeout_err      <= 1'b0;
            acc              <= '0;
            acc_ovf          <= 1'b0;
            cnt              <= '0;
        end else begin
            in_ready    <= (state_nxt == IDLE);
            mul_start   <= (state_nxt == LAUNCH);
            acc_valid   <= 1'b0;
            timeout_err <= timeout_hit;

            if (state == IDLE && in_valid) begin
                mul_multiplicand <= in_a;
                mul_multiplier   <= in_b;
                last_q           <= in_last;
            end

            if (state_nxt == LAUNCH) begin
                cnt <= '0;
            end else if (state == WAIT_LOW || state == WAIT_HIGH) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == ACCUM) begin
                acc     <= sum_sat;
                acc_ovf <= ovf_nxt;
                // The result is published on the edge into DONE so that
                // acc_valid is high during the DONE cycle itself.
                if (last_q) begin
                    acc_out      <= sum_sat;
                    acc_overflow <= ovf_nxt;
                    acc_valid    <= 1'b1;
                end
            end

            if (state == DONE || timeout_hit) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a behavioural Booth-multiplier model answers the
// handshake, a driver issues directed and random dot products, and a monitor
// compares every acc_valid / timeout_err / mul_start event against queues.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic [15:0] mul_multiplicand;
    logic [15:0] mul_multiplier;
    logic        mul_start;
    logic [15:0] mul_result;
    logic        mul_overflow;
    logic        mul_finish;
    logic [15:0] acc_out;
    logic        acc_valid;
    logic        acc_overflow;
    logic        timeout_err;

    always #5 clk = ~clk;

    mac_sequencer #(.TIMEOUT(40)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_last          (in_last),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_start        (mul_start),
        .mul_result       (mul_result),
        .mul_overflow     (mul_overflow),
        .mul_finish       (mul_finish),
        .acc_out          (acc_out),
        .acc_valid        (acc_valid),
        .acc_overflow     (acc_overflow),
        .timeout_err      (timeout_err)
    );

    typedef struct packed {
        bit          is_to;
        logic [15:0] val;
        bit          ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] op_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;
    int          n_terms  = 0;
    bit          hang = 1'b0;
    int          lat_override = 0;
    logic [15:0] da[8];
    logic [15:0] db[8];
    int          dn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Q9.7 product with saturation; returns {overflow, result}.
    function automatic logic [16:0] mul_q(input logic [15:0] a, input logic [15:0] b);
        int sa, sb, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = (sa * sb) >>> 7;
        if (p > 32767)  return {1'b1, 16'h7FFF};
        if (p < -32768) return {1'b1, 16'h8000};
        return {1'b0, p[15:0]};
    endfunction

    // Reference dot product over da/db: each term clipped to range,
    // running sum clipped to range, overflow if any clipping occurred.
    function automatic logic [16:0] ref_dot();
        int acc, p, sa, sb;
        bit ov;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < dn; i++) begin
            sa = int'($signed(da[i]));
            sb = int'($signed(db[i]));
            p  = (sa * sb) >>> 7;
            if (p > 32767)  begin p = 32767;  ov = 1'b1; end
            if (p < -32768) begin p = -32768; ov = 1'b1; end
            acc = acc + p;
            if (acc > 32767)  begin acc = 32767;  ov = 1'b1; end
            if (acc < -32768) begin acc = -32768; ov = 1'b1; end
        end
        return {ov, acc[15:0]};
    endfunction

    function automatic logic [15:0] rnd_val();
        if ($urandom_range(0, 7) == 0) return 16'($urandom());
        return 16'($urandom_range(0, 2047)) - 16'd1024;
    endfunction

    // Multiplier model: drops finish on start, raises it with the product
    // after a random latency, and holds it high until the next start.
    int lat_cnt;
    bit busy;
    logic [16:0] prod;
    always @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            mul_finish   <= 1'b1;
            mul_result   <= 16'h0000;
            mul_overflow <= 1'b0;
        end else if (mul_start) begin
            mul_finish <= 1'b0;
            busy       <= 1'b1;
            lat_cnt    <= (lat_override != 0) ? lat_override : int'($urandom_range(1, 6));
        end else if (busy && !hang) begin
            if (lat_cnt == 0) begin
                prod          = mul_q(mul_multiplicand, mul_multiplier);
                mul_result   <= prod[15:0];
                mul_overflow <= prod[16];
                mul_finish   <= 1'b1;
                busy         <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Monitor: compares DUT events against the scoreboard queues.
    exp_t        e_mon;
    logic [31:0] o_mon;
    always @(negedge clk) begin
        if (!rst) begin
            if (mul_start) begin
                n_starts++;
                if (op_q.size() == 0) begin
                    check("unexpected_mul_start", 32'd1, 32'd0);
                end else begin
                    o_mon = op_q.pop_front();
                    check("mul_operands", {mul_multiplicand, mul_multiplier}, o_mon);
                end
            end
            if (acc_valid || timeout_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, acc_valid, timeout_err}, 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (e_mon.is_to) begin
                        check("timeout_kind", {30'd0, acc_valid, timeout_err}, 32'd1);
                    end else begin
                        check("result_kind", {30'd0, acc_valid, timeout_err}, 32'd2);
                        check("acc_out", {16'd0, acc_out}, {16'd0, e_mon.val});
                        check("acc_overflow", {31'd0, acc_overflow}, {31'd0, e_mon.ovf});
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_term(input logic [15:0] a, input logic [15:0] b, input bit last);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        op_q.push_back({a, b});
        n_terms++;
        wait_ready();
        @(negedge clk);
        in_valid = 1'b0;
        check("mul_start_latency", {31'd0, mul_start}, 32'd1);
    endtask

    task automatic send_dot(input logic [15:0] ev, input bit eo);
        exp_t e;
        for (int i = 0; i < dn; i++) begin
            if (i == dn - 1) begin
                e.is_to = 1'b0;
                e.val   = ev;
                e.ovf   = eo;
                exp_q.push_back(e);
            end
            send_term(da[i], db[i], (i == dn - 1));
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || !in_ready) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] r;
        exp_t        e;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = 16'h0;
        in_b     = 16'h0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mul_start", {31'd0, mul_start}, 32'd0);
        check("rst_operands", {mul_multiplicand, mul_multiplier}, 32'd0);
        check("rst_acc_out", {16'd0, acc_out}, 32'd0);
        check("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        check("rst_acc_overflow", {31'd0, acc_overflow}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // Single term 2.0 * 3.0.
        dn = 1; da[0] = 16'h0100; db[0] = 16'h0180;
        send_dot(16'h0300, 1'b0);
        drain(200);

        // 1.5*2.0 + (-1.0)*0.5 = 2.5.
        dn = 2; da[0] = 16'h00C0; db[0] = 16'h0100; da[1] = 16'hFF80; db[1] = 16'h0040;
        send_dot(16'h0140, 1'b0);
        drain(200);

        // Multiplier overflow, then a clean dot product clears the flag.
        dn = 1; da[0] = 16'h6400; db[0] = 16'h6400;
        send_dot(16'h7FFF, 1'b1);
        dn = 1; da[0] = 16'h0080; db[0] = 16'h0080;
        send_dot(16'h0080, 1'b0);
        drain(200);

        // Addition saturates: 200 + 100.
        dn = 2; da[0] = 16'h6400; db[0] = 16'h0080; da[1] = 16'h3200; db[1] = 16'h0080;
        send_dot(16'h7FFF, 1'b1);
        drain(200);

        // One good term, then a term whose multiplier never finishes.
        send_term(16'h0100, 16'h0100, 1'b0);
        @(negedge clk);
        wait_ready();
        hang    = 1'b1;
        e.is_to = 1'b1;
        e.val   = 16'h0;
        e.ovf   = 1'b0;
        exp_q.push_back(e);
        send_term(16'h0200, 16'h0200, 1'b1);
        drain(300);
        hang = 1'b0;
        // Accumulator must start from zero after the abort.
        dn = 1; da[0] = 16'h0080; db[0] = 16'h0180;
        send_dot(16'h0180, 1'b0);
        drain(200);

        // Reset while waiting for finish high, after one term accumulated.
        send_term(16'h0100, 16'h0080, 1'b0);
        @(negedge clk);
        wait_ready();
        lat_override = 12;
        send_term(16'h0100, 16'h0100, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_mul_start", {31'd0, mul_start}, 32'd0);
        check("midrst_acc_out", {16'd0, acc_out}, 32'd0);
        check("midrst_acc_overflow", {31'd0, acc_overflow}, 32'd0);
        check("midrst_operands", {mul_multiplicand, mul_multiplier}, 32'd0);
        lat_override = 0;
        dn = 2; da[0] = 16'h0080; db[0] = 16'h0200; da[1] = 16'hFF00; db[1] = 16'h0080;
        send_dot(16'h0100, 1'b0);
        drain(200);

        // Random dot products against the reference model.
        for (int t = 0; t < 40; t++) begin
            dn = int'($urandom_range(1, 5));
            for (int i = 0; i < dn; i++) begin
                da[i] = rnd_val();
                db[i] = rnd_val();
            end
            r = ref_dot();
            send_dot(r[15:0], r[16]);
        end
        drain(500);

        check("op_queue_empty", op_q.size(), 32'd0);
        check("start_count", n_starts, n_terms);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
